// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter with fetch handshake, halt/resume and optional return stack (PC_RAS_EN)
module pc_sequencer #(
    parameter int               WIDTH        = 17,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] offset_i,
    input  logic             absolute_i,
    input  logic             advance_i,
    input  logic             halt_i,
    input  logic             resume_i,
    input  logic             call_i,
    input  logic             ret_i,
    input  logic             fetch_ready_i,
    output logic [WIDTH-1:0] pc_o,
    output logic             fetch_valid_o,
    output logic             halted_o,
    output logic             wrapped_o,
    output logic             ras_underflow_o
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic             halt_pending_q, halt_pending_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             wrapped_q, wrapped_d;
    logic             apply;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] pc_inc;

    assign apply   = (state_q == ST_EXEC) && advance_i;
    assign sum_ext = {1'b0, pc_q} + {1'b0, offset_i};
    assign pc_inc  = pc_q + {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q        <= ST_BOOT;
            halt_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            halt_pending_q <= halt_pending_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        halt_pending_d = halt_pending_q;
        case (state_q)
            ST_BOOT: state_d = ST_FETCH;
            ST_FETCH: begin
                // A completed handshake beats a concurrent halt; the halt is deferred.
                if (fetch_ready_i) begin
                    state_d = ST_EXEC;
                    if (halt_i) begin
                        halt_pending_d = 1'b1;
                    end
                end else if (halt_i) begin
                    state_d = ST_HALTED;
                end
            end
            ST_EXEC: begin
                if (advance_i) begin
                    if (halt_i || halt_pending_q) begin
                        state_d        = ST_HALTED;
                        halt_pending_d = 1'b0;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_HALTED: begin
                if (resume_i && !halt_i) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        fetch_valid_o = (state_q == ST_FETCH);
        halted_o      = (state_q == ST_HALTED);
    end

`ifdef PC_RAS_EN
    localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [IDX_W-1:0] top_q, top_next, top_prev;
    logic [CNT_W-1:0] count_q;
    logic             underflow_q, underflow_d;
    logic             do_pop, do_push;

    assign top_next = (top_q == IDX_W'(RAS_DEPTH - 1)) ? '0 : top_q + 1'b1;
    assign top_prev = (top_q == '0) ? IDX_W'(RAS_DEPTH - 1) : top_q - 1'b1;
    assign do_pop   = apply && ret_i && (count_q != '0);
    assign do_push  = apply && call_i && !ret_i;

    always_comb begin
        pc_d        = pc_q;
        wrapped_d   = wrapped_q;
        underflow_d = 1'b0;
        if (apply) begin
            if (ret_i) begin
                if (count_q != '0) begin
                    pc_d = ras_q[top_q];
                end else begin
                    pc_d        = pc_inc;
                    underflow_d = 1'b1;
                end
            end else if (absolute_i) begin
                pc_d = offset_i;
            end else begin
                pc_d      = sum_ext[WIDTH-1:0];
                wrapped_d = wrapped_q | sum_ext[WIDTH];
            end
        end
    end

    // Circular storage: a push when full lands on the oldest slot.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            top_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else if (do_pop) begin
            top_q   <= top_prev;
            count_q <= count_q - 1'b1;
        end else if (do_push) begin
            top_q           <= top_next;
            ras_q[top_next] <= pc_inc;
            if (count_q != CNT_W'(RAS_DEPTH)) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            underflow_q <= 1'b0;
        end else begin
            underflow_q <= underflow_d;
        end
    end

    assign ras_underflow_o = underflow_q;
`else
    logic unused_ras;
    assign unused_ras = call_i | ret_i;

    always_comb begin
        pc_d      = pc_q;
        wrapped_d = wrapped_q;
        if (apply) begin
            if (absolute_i) begin
                pc_d = offset_i;
            end else begin
                pc_d      = sum_ext[WIDTH-1:0];
                wrapped_d = wrapped_q | sum_ext[WIDTH];
            end
        end
    end

    assign ras_underflow_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc_q      <= RESET_VECTOR;
            wrapped_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign pc_o      = pc_q;
    assign wrapped_o = wrapped_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer fetch addresses and status flags
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [16:0] offset;
    logic        absolute, advance, halt, resume, call, ret, ready;
    logic [16:0] pc;
    logic        fv, halted, wrapped, uf;

    int checks = 0;
    int errors = 0;
    logic [16:0] exp_q [$];

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .offset_i       (offset),
        .absolute_i     (absolute),
        .advance_i      (advance),
        .halt_i         (halt),
        .resume_i       (resume),
        .call_i         (call),
        .ret_i          (ret),
        .fetch_ready_i  (ready),
        .pc_o           (pc),
        .fetch_valid_o  (fv),
        .halted_o       (halted),
        .wrapped_o      (wrapped),
        .ras_underflow_o(uf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted fetch must match the next expected address.
    always @(negedge clk) begin
        if (rst_n && fv && ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL fetch_unexpected: got pc %0h expected no fetch", pc);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                if (pc !== e) begin
                    errors++;
                    $display("FAIL fetch_pc: got %0h expected %0h", pc, e);
                end
            end
        end
    end

    task automatic wait_hs();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (fv && ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            chk("handshake_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic adv(input logic [16:0] off, input logic ab, input logic cl, input logic rt,
                       input logic [16:0] exp_pc, input bit push_exp);
        wait_hs();
        @(posedge clk); #1;
        halt     = 1'b0;
        offset   = off;
        absolute = ab;
        call     = cl;
        ret      = rt;
        advance  = 1'b1;
        if (push_exp) exp_q.push_back(exp_pc);
        @(posedge clk); #1;
        advance  = 1'b0;
        call     = 1'b0;
        ret      = 1'b0;
        absolute = 1'b0;
        offset   = 17'h0;
    endtask

    initial begin
        rst_n = 1'b0; offset = '0; absolute = 0; advance = 0; halt = 0;
        resume = 0; call = 0; ret = 0; ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_fv", fv, 32'd0);
        chk("rst_halted", halted, 32'd0);
        chk("rst_wrapped", wrapped, 32'd0);
        chk("rst_uf", uf, 32'd0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.push_back(17'h0);
        @(negedge clk);
        chk("boot_fv_low", fv, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_fv", fv, 32'd1);
            chk("stall_pc", pc, 32'h0);
        end
        @(posedge clk); #1;
        ready = 1'b1;

        adv(17'h1, 0, 0, 0, 17'h1, 1);
        adv(17'h1FFFE, 1, 0, 0, 17'h1FFFE, 1);
        chk("abs_no_wrap", wrapped, 32'd0);
        adv(17'h5, 0, 0, 0, 17'h3, 1);
        chk("wrap_set", wrapped, 32'd1);
        adv(17'h100, 1, 0, 0, 17'h100, 1);
        adv(17'h0, 0, 0, 0, 17'h100, 1);
        chk("wrap_sticky", wrapped, 32'd1);

        // Halt during a successful handshake: executes, then halts after Advance.
        halt = 1'b1;
        adv(17'h10, 0, 0, 0, 17'h0, 0);
        @(negedge clk);
        chk("halted_set", halted, 32'd1);
        chk("halted_pc", pc, 32'h110);
        chk("halted_fv", fv, 32'd0);
        @(posedge clk); #1;
        advance = 1'b1; offset = 17'h7;
        repeat (2) @(posedge clk);
        #1;
        advance = 1'b0; offset = 17'h0;
        chk("halted_adv_ignored", pc, 32'h110);
        halt = 1'b1; resume = 1'b1;
        @(posedge clk); #1;
        chk("halt_resume_stay", halted, 32'd1);
        halt = 1'b0;
        exp_q.push_back(17'h110);
        @(posedge clk); #1;
        resume = 1'b0;
        chk("resumed", halted, 32'd0);

        // Halt with no handshake aborts the fetch; it is reissued after Resume.
        adv(17'h1, 0, 0, 0, 17'h111, 1);
        ready = 1'b0; halt = 1'b1;
        @(posedge clk); #1;
        halt = 1'b0;
        @(negedge clk);
        chk("abort_halted", halted, 32'd1);
        chk("abort_fv", fv, 32'd0);
        chk("abort_pc", pc, 32'h111);
        @(posedge clk); #1;
        ready = 1'b1; resume = 1'b1;
        @(posedge clk); #1;
        resume = 1'b0;

`ifdef PC_RAS_EN
        adv(17'h10, 1, 0, 0, 17'h10, 1);
        adv(17'h40, 1, 1, 0, 17'h40, 1);
        adv(17'h999, 0, 0, 1, 17'h11, 1);
        chk("ret_no_uf", uf, 32'd0);
        adv(17'h200, 1, 1, 0, 17'h200, 1);
        adv(17'h1, 0, 1, 0, 17'h201, 1);
        adv(17'h1, 0, 1, 0, 17'h202, 1);
        adv(17'h1, 0, 1, 0, 17'h203, 1);
        adv(17'h1, 0, 1, 0, 17'h204, 1);
        adv(17'h0, 0, 0, 1, 17'h204, 1);
        adv(17'h0, 0, 0, 1, 17'h203, 1);
        adv(17'h0, 0, 0, 1, 17'h202, 1);
        adv(17'h0, 0, 0, 1, 17'h201, 1);
        chk("ret4_no_uf", uf, 32'd0);
        adv(17'h0, 0, 0, 1, 17'h202, 1);
        chk("uf_pulse", uf, 32'd1);
        adv(17'h300, 1, 1, 0, 17'h300, 1);
        chk("uf_cleared", uf, 32'd0);
        adv(17'h50, 1, 1, 1, 17'h203, 1);
        adv(17'h0, 0, 0, 1, 17'h204, 1);
        chk("uf_pulse2", uf, 32'd1);
`else
        adv(17'h10, 1, 0, 0, 17'h10, 1);
        adv(17'h2, 0, 1, 1, 17'h12, 1);
        chk("no_ras_uf", uf, 32'd0);
        adv(17'h3, 0, 0, 1, 17'h15, 1);
        chk("no_ras_uf2", uf, 32'd0);
`endif

        // Async reset while a fetch is outstanding.
        adv(17'h1, 0, 0, 0, 17'h0, 0);
        ready = 1'b0;
        @(negedge clk);
        chk("pre_reset_fv", fv, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_fv_drop", fv, 32'd0);
        chk("async_pc", pc, 32'h0);
        chk("async_wrapped", wrapped, 32'd0);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
